// File: rtl/m2p_funnel_mux.sv
// m2p_funnel_mux: funnels NCH method-call channels into one beat pipe as header + NB data beats, round-robin.
module m2p_funnel_mux #(
  parameter int NCH = 4,
  parameter int PW = 128,
  parameter int BW = 64,
  parameter int ID_BASE = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NCH-1:0]    heard__ENA,
  input  logic [NCH*PW-1:0] heard__v,
  output logic [NCH-1:0]    heard__RDY,
  input  logic              enq__RDY,
  output logic              enq__ENA,
  output logic [BW-1:0]     enq__v,
  output logic              enq__last,
  output logic              busy
);
  localparam int NB = PW / BW;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam int BCW = NB > 1 ? $clog2(NB) : 1;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  state_t state;
  logic [NCH-1:0] full, acc, clr;
  logic [PW-1:0] slot [NCH];
  logic [PW-1:0] sh;
  logic [CW-1:0] ptr, id, gnt;
  logic gnt_vld;
  logic [BCW-1:0] cnt;
  logic [BW-1:0] hdr;
  // later iterations are closer to ptr+1, so the last hit wins
  always_comb begin
    int j;
    j = 0;
    gnt_vld = 1'b0;
    gnt = '0;
    for (int k = NCH; k >= 1; k--) begin
      j = (int'(ptr) + k) % NCH;
      if (full[j]) begin
        gnt_vld = 1'b1;
        gnt = CW'(j);
      end
    end
  end
  always_comb begin
    hdr = '0;
    hdr[15:0] = 16'(NB + 1);
    hdr[31:16] = 16'(ID_BASE) + 16'(id);
  end
  assign acc = heard__ENA & ~full;
  assign clr = (state == IDLE && gnt_vld) ? (NCH'(1) << gnt) : '0;
  assign heard__RDY = ~full;
  assign enq__ENA = state != IDLE && enq__RDY;
  assign enq__v = state == HDR ? hdr : state == DATA ? sh[BW-1:0] : '0;
  assign enq__last = state == DATA && cnt == BCW'(NB - 1);
  assign busy = |full || state != IDLE;
  always_ff @(posedge CLK)
    for (int i = 0; i < NCH; i++)
      if (acc[i]) slot[i] <= heard__v[i*PW +: PW];
  always_ff @(posedge CLK) begin
    if (RST) begin
      full <= '0;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      ptr <= CW'(NCH - 1);
      id <= '0;
    end else begin
      full <= (full & ~clr) | acc;
      case (state)
        IDLE: if (gnt_vld) begin
          sh <= slot[gnt];
          id <= gnt;
          ptr <= gnt;
          cnt <= '0;
          state <= HDR;
        end
        HDR: if (enq__RDY) state <= DATA;
        default: if (enq__RDY) begin
          sh <= sh >> BW;
          cnt <= enq__last ? '0 : cnt + 1'b1;
          state <= enq__last ? IDLE : DATA;
        end
      endcase
    end
  end
endmodule
